// File: rtl/l1_cache.sv
//------------------------------------------------------------------------------
// l1_cache
//
// Direct-mapped, write-through, no-write-allocate L1 cache between the core
// and one port of main memory. Hits are served from flop storage. Read misses
// refill a whole 4-word line with four back-to-back memory reads. Every write
// goes straight to memory, and a write that hits also updates the cached word.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   flush          invalidate every line; only acted on while idle
//   core_req       request valid, held until core_ready
//   core_we        1 = write, 0 = read
//   core_addr      byte address (bits [1:0] ignored)
//   core_wdata     write data
//   core_be        write byte enables
//   core_rdata     read data, non-zero only while core_ready on a read
//   core_ready     one-cycle completion pulse
//   mem_addr       main-memory word address
//   mem_data_i     write data towards memory
//   mem_data_o     read data from memory, one cycle after mem_addr
//   mem_data_en    byte enables (1111 on refill, core_be on write, 0 idle)
//   mem_write_en   1 = memory write
//------------------------------------------------------------------------------
module l1_cache #(
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [31:0]           core_wdata,
    input  logic [3:0]            core_be,
    output logic [31:0]           core_rdata,
    output logic                  core_ready,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_data_i,
    input  logic [31:0]           mem_data_o,
    output logic [3:0]            mem_data_en,
    output logic                  mem_write_en
);

    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 4;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REFILL,
        FILL_LAST
    } state_t;

    state_t state;
    state_t state_next;

    // Latched request; only the word address is kept since the byte bits
    // never matter to the cache or to memory.
    logic [ADDR_WIDTH-3:0] req_waddr;
    logic                  req_we;
    logic [31:0]           req_wdata;
    logic [3:0]            req_be;
    logic [1:0]            refill_cnt;

    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags  [LINES];
    logic [31:0]           lines [LINES][4];

    logic [1:0]            req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic                  hit;
    logic                  unused_byte_bits;

    assign req_off          = req_waddr[1:0];
    assign req_idx          = req_waddr[INDEX_BITS+1:2];
    assign req_tag          = req_waddr[ADDR_WIDTH-3:INDEX_BITS+2];
    assign hit              = valid[req_idx] && (tags[req_idx] == req_tag);
    assign unused_byte_bits = ^core_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Control state: request latch, refill counter and valid bits. Reset here
    // abandons any refill in flight and leaves every line invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_waddr  <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            req_be     <= '0;
            refill_cnt <= '0;
            valid      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Flush wins; a simultaneous request is still held and
                    // gets accepted on the following cycle.
                    if (flush) begin
                        valid <= '0;
                    end else if (core_req) begin
                        req_waddr <= core_addr[ADDR_WIDTH-1:2];
                        req_we    <= core_we;
                        req_wdata <= core_wdata;
                        req_be    <= core_be;
                    end
                end
                COMPARE: begin
                    if (!req_we && !hit) begin
                        refill_cnt <= '0;
                    end
                end
                REFILL: begin
                    refill_cnt <= refill_cnt + 2'd1;
                end
                FILL_LAST: begin
                    valid[req_idx] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; the valid bits alone decide
    // whether their contents mean anything. Memory data lags the address by
    // one cycle, so each refill cycle captures the word requested previously.
    always_ff @(posedge clk) begin
        case (state)
            COMPARE: begin
                if (req_we && hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_be[b]) begin
                            lines[req_idx][req_off][8*b +: 8] <= req_wdata[8*b +: 8];
                        end
                    end
                end
            end
            REFILL: begin
                if (refill_cnt != 2'd0) begin
                    lines[req_idx][refill_cnt - 2'd1] <= mem_data_o;
                end
            end
            FILL_LAST: begin
                lines[req_idx][3] <= mem_data_o;
                tags[req_idx]     <= req_tag;
            end
            default: begin
            end
        endcase
    end

    // Next state and all outputs. Outputs depend only on state and the
    // latched request, so an idle cache presents an all-zero memory port.
    always_comb begin
        state_next   = state;
        core_ready   = 1'b0;
        core_rdata   = '0;
        mem_addr     = '0;
        mem_data_i   = '0;
        mem_data_en  = '0;
        mem_write_en = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && core_req) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (req_we) begin
                    mem_write_en = 1'b1;
                    mem_addr     = req_waddr;
                    mem_data_i   = req_wdata;
                    mem_data_en  = req_be;
                    core_ready   = 1'b1;
                    state_next   = IDLE;
                end else if (hit) begin
                    core_ready = 1'b1;
                    core_rdata = lines[req_idx][req_off];
                    state_next = IDLE;
                end else begin
                    state_next = REFILL;
                end
            end
            REFILL: begin
                mem_addr    = {req_tag, req_idx, refill_cnt};
                mem_data_en = 4'b1111;
                if (refill_cnt == 2'd3) begin
                    state_next = FILL_LAST;
                end
            end
            FILL_LAST: begin
                state_next = COMPARE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_l1_cache.sv
//------------------------------------------------------------------------------
// tb_l1_cache
//
// Drives l1_cache with directed and random requests against a behavioural
// main memory, and predicts hit/miss, latency, memory traffic and read data
// from a line-level model of the cache plus a reference copy of memory.
//------------------------------------------------------------------------------
module tb_l1_cache;

    localparam int LINES = 64;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [3:0]  core_be;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic [3:0]  mem_data_en;
    logic        mem_write_en;

    int n_checks;
    int n_fail;

    // Memory seen by the DUT, and the bench's own expectation of memory.
    logic [31:0] env_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] env_word;

    // Line-level cache model: which tag, if any, each line holds.
    bit          model_valid [LINES];
    int unsigned model_tag   [LINES];

    l1_cache #(
        .ADDR_WIDTH(32),
        .INDEX_BITS(6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_be     (core_be),
        .core_rdata  (core_rdata),
        .core_ready  (core_ready),
        .mem_addr    (mem_addr),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .mem_data_en (mem_data_en),
        .mem_write_en(mem_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] envRead(input int unsigned w);
        if (env_mem.exists(w)) return env_mem[w];
        return initWord(w);
    endfunction

    function automatic logic [31:0] refRead(input int unsigned w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return initWord(w);
    endfunction

    // Main memory: synchronous read, byte-enabled write.
    always @(posedge clk) begin
        if (mem_write_en) begin
            env_word = envRead(32'(mem_addr));
            for (int b = 0; b < 4; b++) begin
                if (mem_data_en[b]) env_word[8*b +: 8] = mem_data_i[8*b +: 8];
            end
            env_mem[32'(mem_addr)] = env_word;
        end
        mem_data_o <= envRead(32'(mem_addr));
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_core_ready"},   64'(core_ready),   64'd0);
        checkOutput({tag, "_core_rdata"},   64'(core_rdata),   64'd0);
        checkOutput({tag, "_mem_addr"},     64'(mem_addr),     64'd0);
        checkOutput({tag, "_mem_data_i"},   64'(mem_data_i),   64'd0);
        checkOutput({tag, "_mem_data_en"},  64'(mem_data_en),  64'd0);
        checkOutput({tag, "_mem_write_en"}, 64'(mem_write_en), 64'd0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    endtask

    task automatic doFlush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clearModel();
    endtask

    // One complete request. With flush_same the flush is raised in the same
    // cycle as the request, so everything shifts one cycle later.
    task automatic applyStimulus(input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be,
                                 input bit flush_same);
        int unsigned waddr;
        int unsigned line;
        int unsigned idx;
        int unsigned tag;
        int          shift;
        bit          hit;
        logic [31:0] exp_rdata;
        logic [31:0] merged;
        int          ready_cyc;
        logic [31:0] rdata;
        int          n_acc;
        int          first_acc;
        int          n_rd;
        logic [29:0] rd_addr [4];
        int          wr_cyc;
        logic [29:0] wr_addr;
        logic [31:0] wr_data;
        logic [3:0]  wr_be;

        waddr = addr >> 2;
        line  = addr >> 4;
        idx   = line % LINES;
        tag   = addr >> 10;
        shift = flush_same ? 1 : 0;
        if (flush_same) clearModel();
        hit       = model_valid[idx] && (model_tag[idx] == tag);
        exp_rdata = refRead(waddr);

        ready_cyc = 0;
        rdata     = '0;
        n_acc     = 0;
        first_acc = 0;
        n_rd      = 0;
        wr_cyc    = 0;
        wr_addr   = '0;
        wr_data   = '0;
        wr_be     = '0;
        for (int k = 0; k < 4; k++) rd_addr[k] = '0;

        @(negedge clk);
        core_req   = 1'b1;
        core_we    = we;
        core_addr  = addr;
        core_wdata = wdata;
        core_be    = be;
        flush      = flush_same;

        for (int cyc = 1; cyc <= 15 && ready_cyc == 0; cyc++) begin
            @(negedge clk);
            flush = 1'b0;
            if (mem_write_en || mem_data_en != 4'd0) begin
                n_acc++;
                if (first_acc == 0) first_acc = cyc;
            end
            if (mem_write_en) begin
                wr_cyc  = cyc;
                wr_addr = mem_addr;
                wr_data = mem_data_i;
                wr_be   = mem_data_en;
            end else if (mem_data_en != 4'd0 && n_rd < 4) begin
                rd_addr[n_rd] = mem_addr;
                n_rd++;
            end
            if (core_ready) begin
                ready_cyc = cyc;
                rdata     = core_rdata;
                core_req  = 1'b0;
            end
        end
        core_req = 1'b0;

        if (we) begin
            checkOutput("wr_ready_cyc", 64'(ready_cyc), 64'(1 + shift));
            checkOutput("wr_cyc",       64'(wr_cyc),    64'(1 + shift));
            checkOutput("wr_addr",      64'(wr_addr),   64'(waddr));
            checkOutput("wr_data",      64'(wr_data),   64'(wdata));
            checkOutput("wr_be",        64'(wr_be),     64'(be));
            checkOutput("wr_accesses",  64'(n_acc),     64'd1);
            merged = refRead(waddr);
            for (int b = 0; b < 4; b++) begin
                if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
            end
            ref_mem[waddr] = merged;
        end else if (hit) begin
            checkOutput("hit_ready_cyc", 64'(ready_cyc), 64'(1 + shift));
            checkOutput("hit_rdata",     64'(rdata),     64'(exp_rdata));
            checkOutput("hit_accesses",  64'(n_acc),     64'd0);
        end else begin
            checkOutput("miss_ready_cyc", 64'(ready_cyc), 64'(7 + shift));
            checkOutput("miss_rdata",     64'(rdata),     64'(exp_rdata));
            checkOutput("miss_accesses",  64'(n_acc),     64'd4);
            checkOutput("miss_first_rd",  64'(first_acc), 64'(2 + shift));
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("miss_rd_addr%0d", k), 64'(rd_addr[k]), 64'(line * 4 + k));
            end
            model_valid[idx] = 1'b1;
            model_tag[idx]   = tag;
        end
    endtask

    // Watchdog so a stuck handshake still ends the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          idx_pool [4];
        int unsigned a;
        bit          we;
        bit          fs;

        idx_pool[0] = 16;
        idx_pool[1] = 17;
        idx_pool[2] = 63;
        idx_pool[3] = 0;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_be    = '0;
        clearModel();

        env_mem[32'h40] = 32'h11;  ref_mem[32'h40] = 32'h11;
        env_mem[32'h41] = 32'h22;  ref_mem[32'h41] = 32'h22;
        env_mem[32'h42] = 32'h33;  ref_mem[32'h42] = 32'h33;
        env_mem[32'h43] = 32'h44;  ref_mem[32'h43] = 32'h44;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // Basic miss, hit, partial write, write-hit merge.
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0108, 32'hAAAA_BBBB, 4'b0011, 1'b0);
        applyStimulus(1'b0, 32'h0000_0108, 32'h0, 4'h0, 1'b0);
        checkOutput("merged_word", 64'(refRead(32'h42)), 64'h0000_BBBB);

        // No-write-allocate.
        applyStimulus(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b1111, 1'b0);
        applyStimulus(1'b0, 32'h0000_2000, 32'h0, 4'h0, 1'b0);

        // Flush invalidates a resident line.
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        doFlush();
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);

        // Conflict on one index, then flush together with a request.
        applyStimulus(1'b0, 32'h0000_0500, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0500, 32'h0, 4'h0, 1'b1);

        // Reset in the middle of a refill (third refill cycle = cycle 4).
        @(negedge clk);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h0000_0100;
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_refill_en", 64'(mem_data_en), 64'hF);
        checkOutput("pre_reset_refill_addr", 64'(mem_addr), 64'h42);
        rst_n    = 1'b0;
        core_req = 1'b0;
        #1;
        checkResetOutputs("mid_reset");
        @(negedge clk);
        checkResetOutputs("held_reset");
        rst_n = 1'b1;
        clearModel();
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0);

        // Random traffic over a few contended lines.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 15) == 0) doFlush();
            a  = ($urandom_range(0, 2) << 10) | (idx_pool[$urandom_range(0, 3)] << 4)
               | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            we = ($urandom_range(0, 2) == 0);
            fs = ($urandom_range(0, 19) == 0);
            applyStimulus(we, a, $urandom, 4'($urandom_range(0, 15)), fs);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
